// File: rtl/pending_index_encoder.sv
// Sequential priority encoder: captures a word mask and emits the index of each set bit,
// one per valid/ready handshake. Define ENC_MSB_FIRST_EN to emit highest index first.
module pending_index_encoder #(
  parameter int N_WORDS = 32,
  parameter int AW      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [N_WORDS-1:0] mask_in,
  output logic [AW-1:0]      idx_out,
  output logic               idx_valid,
  input  logic               idx_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [N_WORDS-1:0] pending_q, pending_d;
  logic [AW-1:0]      sel_idx;
  logic [N_WORDS-1:0] sel_onehot;

  // The last assignment in the loop wins, so the scan direction sets the priority.
  always_comb begin
    sel_idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N_WORDS; i++) begin
      if (pending_q[i]) sel_idx = AW'(i);
    end
`else
    for (int i = N_WORDS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = AW'(i);
    end
`endif
  end

  assign sel_onehot = N_WORDS'(1) << sel_idx;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    busy      = 1'b0;
    idx_valid = 1'b0;
    idx_out   = '0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          pending_d = mask_in;
          state_d   = (mask_in != '0) ? ST_SCAN : ST_FINISH;
        end
      end
      ST_SCAN: begin
        busy      = 1'b1;
        idx_valid = (pending_q != '0);
        idx_out   = sel_idx;
        if (idx_valid && idx_ready) begin
          pending_d = pending_q & ~sel_onehot;
          if (pending_d == '0) state_d = ST_FINISH;
        end else if (!idx_valid) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        pending_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_pending_index_encoder.sv
// Bench for pending_index_encoder: directed cases plus random masks, checked against a
// queue-of-indices model of the expected emission order.
module tb_pending_index_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [31:0] mask_in;
  logic [4:0]  idx_out;
  logic        idx_valid;
  logic        idx_ready;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  // Model: indices still to be emitted, in emission order, plus a coarse phase.
  int mdl_q[$];
  int mdl_phase = 0;  // 0 idle, 1 emitting, 2 completion cycle

  pending_index_encoder #(.N_WORDS(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .mask_in   (mask_in),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic build_order(input logic [31:0] m);
    mdl_q.delete();
    for (int i = 0; i < 32; i++) begin
      if (m[i]) begin
`ifdef ENC_MSB_FIRST_EN
        mdl_q.push_front(i);
`else
        mdl_q.push_back(i);
`endif
      end
    end
  endtask

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = (mdl_phase == 1) && (mdl_q.size() > 0);
    check("busy", {31'd0, busy}, {31'd0, mdl_phase != 0});
    check("idx_valid", {31'd0, idx_valid}, {31'd0, exp_valid});
    check("done", {31'd0, done}, {31'd0, mdl_phase == 2});
    if (exp_valid) check("idx_out", {27'd0, idx_out}, mdl_q[0]);
    else if (mdl_phase == 0) check("idx_out_idle", {27'd0, idx_out}, 32'd0);
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance model across the next rise.
  task automatic step(input logic ld, input logic [31:0] m, input logic rdy);
    @(negedge clk);
    check_outputs();
    $display("[TB] t=%0t ld=%0b mask=%08h rdy=%0b | busy=%0b vld=%0b idx=%0d done=%0b",
             $time, ld, m, rdy, busy, idx_valid, idx_out, done);
    load = ld;
    mask_in = m;
    idx_ready = rdy;
    case (mdl_phase)
      0: if (ld) begin
        build_order(m);
        mdl_phase = (mdl_q.size() > 0) ? 1 : 2;
      end
      1: if (rdy && mdl_q.size() > 0) begin
        void'(mdl_q.pop_front());
        if (mdl_q.size() == 0) mdl_phase = 2;
      end
      default: mdl_phase = 0;
    endcase
  endtask

  task automatic run_until_idle(input int budget, input logic rand_ready);
    int n = 0;
    while (mdl_phase != 0 && n < budget) begin
      step(($urandom_range(0, 3) == 0), $urandom, rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      n++;
    end
    check("drain_timeout", {31'd0, mdl_phase == 0}, 32'd1);
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    mdl_q.delete();
    mdl_phase = 0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, idx_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_idx", {27'd0, idx_out}, 32'd0);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] m;
    rst_n = 1'b0;
    load = 1'b0;
    mask_in = '0;
    idx_ready = 1'b0;
    #1;
    check("por_busy", {31'd0, busy}, 32'd0);
    check("por_valid", {31'd0, idx_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Two ends of the word: 0 then 31 (reversed in the MSB-first build).
    step(1'b1, 32'h8000_0001, 1'b1);
    run_until_idle(10, 1'b0);
    step(1'b0, 32'h0, 1'b1);

    // Empty mask: straight to the completion pulse.
    step(1'b1, 32'h0, 1'b1);
    run_until_idle(4, 1'b0);
    step(1'b0, 32'h0, 1'b1);

    // Stall for three cycles, then drain.
    step(1'b1, 32'h0000_0112, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    run_until_idle(10, 1'b0);

    // Full mask with a competing load part way through.
    step(1'b1, 32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_F00F, 1'b1);
    run_until_idle(40, 1'b0);

    // Load coinciding with the final accept is dropped.
    step(1'b1, 32'h0000_0003, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0010, 1'b1);
    run_until_idle(4, 1'b0);
    step(1'b0, 32'h0, 1'b1);

    // Reset mid-operation discards the rest, then a fresh mask.
    step(1'b1, 32'h0000_00FF, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    async_reset_check();
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0100, 1'b1);
    run_until_idle(6, 1'b0);
    step(1'b0, 32'h0, 1'b1);

    // Random masks with random backpressure and stray loads.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: m = 32'd1 << $urandom_range(0, 31);
        1: m = $urandom & $urandom & $urandom;
        2: m = $urandom;
        default: m = ($urandom_range(0, 1) == 0) ? 32'h0 : ($urandom & $urandom);
      endcase
      step(1'b1, m, ($urandom_range(0, 1) == 1));
      run_until_idle(200, 1'b1);
      if ($urandom_range(0, 1) == 1) step(1'b0, 32'h0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
